exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
Fourth pipeline stage, directly downstream of the decode/issue stage. It latches the issued operands and control, computes the ALU result, or a 32-cycle iterative divide when that option is built in, and forwards the result to the pre-memory stage. It also drives the EXE bypass/wakeup fields that the decode stage uses for forwarding and stall decisions.

Parameters:
DIV_CYCLES, 32, number of RUN-state iterations of the radix-2 restoring divider (one quotient bit per cycle).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
id_to_exe_valid  in  1  decode stage holds a valid issued instruction
exe_allow_in  out  1  EXE can accept an instruction this cycle
exe_to_pmem_valid  out  1  EXE result valid toward PMEM
pmem_allow_in  in  1  PMEM can accept
in_alu_op  in  19  one-hot op: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui (pass src2), 12 mul, 13 mulh, 14 mulhu, 15 div, 16 mod, 17 divu, 18 modu
in_src1, in_src2  in  32 each  operands
in_rf_w_addr  in  5  destination register
in_rf_w_en  in  1  instruction writes the register file
in_rf_w_data_sel  in  1  0 = ALU result, 1 = load data
in_ram_ctrl  in  6  {wd[1:0], extend, we, en, reserved}, passed through unchanged
in_ram_wdata  in  32  store data, passed through unchanged
in_pc  in  32  instruction PC, passed through unchanged
out_alu_result  out  32  ALU or divide result, also used as the data-RAM address
out_rf_w_addr, out_rf_w_en, out_rf_w_data_sel, out_ram_ctrl, out_ram_wdata, out_pc  out  widths as inputs  registered pass-through
by_rf_w_data_valid  out  1  out_alu_result is final and may be forwarded
by_valid  out  1  EXE holds a valid instruction (same value as exe_valid)

Behaviour:
- Reset, asynchronous on resetn low: exe_valid=0, all pass-through registers=0, divider FSM=IDLE, iteration counter=0. Outputs while in reset: exe_to_pmem_valid=0, by_rf_w_data_valid=0, exe_allow_in=1.
- Handshake:
  - exe_ready_go = ~is_div | (fsm==DONE).
  - exe_allow_in = ~exe_valid | (exe_ready_go & pmem_allow_in).
  - exe_to_pmem_valid = exe_valid & exe_ready_go.
  - When exe_allow_in is high, exe_valid takes id_to_exe_valid on the next edge.
  - All input fields are latched only when id_to_exe_valid & exe_allow_in.
  - While stalled, all registered outputs hold.
- Non-divide ops: combinational on the latched operands, zero added latency, ready in the entry cycle.
  - Shifts use src2[4:0].
  - slt compares signed; sltu compares unsigned.
  - mul returns the low 32 bits; mulh returns the high 32 bits of the signed 64-bit product; mulhu returns the high 32 bits of the unsigned product.
- Divider FSM (IDLE, RUN, DONE):
  - IDLE→RUN when exe_valid & is_div. Capture absolute dividend and divisor and result signs; counter=0.
  - RUN: one bit per cycle. After DIV_CYCLES iterations, →DONE.
  - DONE: apply signs. Stay in DONE until exe_ready_go & pmem_allow_in, then →IDLE.
  - Minimum occupancy for a divide is 1 + DIV_CYCLES + 1 = 34 cycles.
  - A back-to-back divide re-enters RUN from IDLE on the cycle after handoff.
- Divide sign and edge rules:
  - Quotient sign = sign(src1) xor sign(src2); remainder sign = sign(src1).
  - Divide by zero: quotient 0xFFFFFFFF, remainder = src1 (signed and unsigned alike).
  - 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0.
- Bypass: by_rf_w_data_valid = exe_valid & in_rf_w_en & ~in_rf_w_data_sel & exe_ready_go. It is therefore never asserted for loads, and asserted for divides only in DONE.
- out_alu_result is a registered copy only for divides; for all other ops it is combinational from the latched operands.

Optional Feature:
EXE_DIV_EN
- Defined: iterative divider and FSM built as specified.
- Undefined: FSM and divider are removed. alu_op bits 15-18 produce result 0 in one cycle, and exe_ready_go is constantly 1.

Test Plan:
- add: src1=0x7FFFFFFF, src2=1, pmem_allow_in=1 → exe_to_pmem_valid the cycle after latch, out_alu_result=0x80000000, by_rf_w_data_valid=1.
- div: src1=-7, src2=2 → exe_allow_in=0 for 33 cycles after entry, then out_alu_result=0xFFFFFFFD. mod of the same operands gives 0xFFFFFFFF. divu of 7/2 gives 3.
- Divide by zero: divu 5/0 → 0xFFFFFFFF; modu 5/0 → 5. Signed overflow: div 0x80000000/0xFFFFFFFF → 0x80000000.
- Backpressure: add issued with pmem_allow_in=0 for 3 cycles → outputs stable, exe_allow_in=0; handoff occurs in the cycle pmem_allow_in rises.
- Load instruction (in_rf_w_data_sel=1, in_rf_w_en=1) → by_rf_w_data_valid=0 while by_valid=1.
- resetn pulsed low mid-divide (RUN, counter=10) → immediately exe_valid=0 and fsm=IDLE; the next instruction after release completes normally.

Source files
------------

// File: rtl/exe_stage.sv
// Execute pipeline stage: latches issued operands, computes the ALU result and hands it to PMEM.
// Optional iterative radix-2 divider built when EXE_DIV_EN is defined; otherwise div/mod ops return 0.
module exe_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_to_exe_valid,
  output logic        exe_allow_in,
  output logic        exe_to_pmem_valid,
  input  logic        pmem_allow_in,
  input  logic [18:0] in_alu_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [4:0]  in_rf_w_addr,
  input  logic        in_rf_w_en,
  input  logic        in_rf_w_data_sel,
  input  logic [5:0]  in_ram_ctrl,
  input  logic [31:0] in_ram_wdata,
  input  logic [31:0] in_pc,
  output logic [31:0] out_alu_result,
  output logic [4:0]  out_rf_w_addr,
  output logic        out_rf_w_en,
  output logic        out_rf_w_data_sel,
  output logic [5:0]  out_ram_ctrl,
  output logic [31:0] out_ram_wdata,
  output logic [31:0] out_pc,
  output logic        by_rf_w_data_valid,
  output logic        by_valid
);

  logic        exe_valid_r;
  logic [18:0] alu_op_r;
  logic [31:0] src1_r;
  logic [31:0] src2_r;
  logic        exe_ready_go_s;
  logic        latch_s;
  logic        is_div_s;
  logic [31:0] alu_s;
  logic [63:0] prod_s;
  logic [31:0] mulhu_s;
  logic [31:0] sra_s;

  assign is_div_s          = |alu_op_r[18:15];
  assign exe_allow_in      = ~exe_valid_r | (exe_ready_go_s & pmem_allow_in);
  assign exe_to_pmem_valid = exe_valid_r & exe_ready_go_s;
  assign latch_s           = id_to_exe_valid & exe_allow_in;
  assign by_valid          = exe_valid_r;
  assign by_rf_w_data_valid = exe_valid_r & out_rf_w_en & ~out_rf_w_data_sel & exe_ready_go_s;

  // Stage valid flag and latched instruction fields.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exe_valid_r       <= 1'b0;
      alu_op_r          <= 19'd0;
      src1_r            <= 32'd0;
      src2_r            <= 32'd0;
      out_rf_w_addr     <= 5'd0;
      out_rf_w_en       <= 1'b0;
      out_rf_w_data_sel <= 1'b0;
      out_ram_ctrl      <= 6'd0;
      out_ram_wdata     <= 32'd0;
      out_pc            <= 32'd0;
    end else begin
      if (exe_allow_in) begin
        exe_valid_r <= id_to_exe_valid;
      end
      if (latch_s) begin
        alu_op_r          <= in_alu_op;
        src1_r            <= in_src1;
        src2_r            <= in_src2;
        out_rf_w_addr     <= in_rf_w_addr;
        out_rf_w_en       <= in_rf_w_en;
        out_rf_w_data_sel <= in_rf_w_data_sel;
        out_ram_ctrl      <= in_ram_ctrl;
        out_ram_wdata     <= in_ram_wdata;
        out_pc            <= in_pc;
      end
    end
  end

  // One signed multiplier; the unsigned high word is recovered with the standard sign correction.
  assign prod_s  = $signed({{32{src1_r[31]}}, src1_r}) * $signed({{32{src2_r[31]}}, src2_r});
  assign mulhu_s = prod_s[63:32] + (src1_r[31] ? src2_r : 32'd0) + (src2_r[31] ? src1_r : 32'd0);
  assign sra_s   = $signed(src1_r) >>> src2_r[4:0];

  // One-hot AND-OR result mux for the single-cycle operations.
  always_comb begin
    alu_s = ({32{alu_op_r[0]}}  & (src1_r + src2_r))
          | ({32{alu_op_r[1]}}  & (src1_r - src2_r))
          | ({32{alu_op_r[2]}}  & {31'd0, $signed(src1_r) < $signed(src2_r)})
          | ({32{alu_op_r[3]}}  & {31'd0, src1_r < src2_r})
          | ({32{alu_op_r[4]}}  & (src1_r & src2_r))
          | ({32{alu_op_r[5]}}  & ~(src1_r | src2_r))
          | ({32{alu_op_r[6]}}  & (src1_r | src2_r))
          | ({32{alu_op_r[7]}}  & (src1_r ^ src2_r))
          | ({32{alu_op_r[8]}}  & (src1_r << src2_r[4:0]))
          | ({32{alu_op_r[9]}}  & (src1_r >> src2_r[4:0]))
          | ({32{alu_op_r[10]}} & sra_s)
          | ({32{alu_op_r[11]}} & src2_r)
          | ({32{alu_op_r[12]}} & prod_s[31:0])
          | ({32{alu_op_r[13]}} & prod_s[63:32])
          | ({32{alu_op_r[14]}} & mulhu_s);
  end

`ifdef EXE_DIV_EN
  localparam int CW = $clog2(DIV_CYCLES) + 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  div_state_e  state_r;
  div_state_e  state_nxt_s;
  logic        start_s;
  logic        run_s;
  logic        last_s;
  logic [CW-1:0] cnt_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dsor_r;
  logic        qneg_r;
  logic        rneg_r;
  logic        dz_r;
  logic [31:0] res_r;
  logic        signed_op_s;
  logic [32:0] rem_sh_s;
  logic [32:0] diff_s;
  logic [31:0] rem_nxt_s;
  logic [31:0] quo_nxt_s;
  logic [31:0] quo_fin_s;
  logic [31:0] rem_fin_s;

  assign signed_op_s = alu_op_r[15] | alu_op_r[16];
  assign last_s      = (cnt_r == CW'(DIV_CYCLES - 1));

  // Divider state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= DIV_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Divider next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      DIV_IDLE: begin
        if (start_s) state_nxt_s = DIV_RUN;
        else         state_nxt_s = DIV_IDLE;
      end
      DIV_RUN: begin
        if (last_s) state_nxt_s = DIV_DONE;
        else        state_nxt_s = DIV_RUN;
      end
      DIV_DONE: begin
        if (exe_ready_go_s & pmem_allow_in) state_nxt_s = DIV_IDLE;
        else                                state_nxt_s = DIV_DONE;
      end
      default: state_nxt_s = DIV_IDLE;
    endcase
  end

  // Divider state outputs.
  always_comb begin
    exe_ready_go_s = ~is_div_s;
    start_s        = 1'b0;
    run_s          = 1'b0;
    case (state_r)
      DIV_IDLE: start_s        = exe_valid_r & is_div_s;
      DIV_RUN:  run_s          = 1'b1;
      DIV_DONE: exe_ready_go_s = 1'b1;
      default:  exe_ready_go_s = ~is_div_s;
    endcase
  end

  // Restoring step: shift in the next dividend bit and subtract when it fits.
  assign rem_sh_s  = {rem_r, quo_r[31]};
  assign diff_s    = rem_sh_s - {1'b0, dsor_r};
  assign rem_nxt_s = diff_s[32] ? rem_sh_s[31:0] : diff_s[31:0];
  assign quo_nxt_s = {quo_r[30:0], ~diff_s[32]};
  assign quo_fin_s = dz_r ? 32'hFFFF_FFFF : (qneg_r ? -quo_nxt_s : quo_nxt_s);
  assign rem_fin_s = rneg_r ? -rem_nxt_s : rem_nxt_s;

  // Divider datapath: capture magnitudes and signs, iterate, then latch the signed result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r  <= {CW{1'b0}};
      rem_r  <= 32'd0;
      quo_r  <= 32'd0;
      dsor_r <= 32'd0;
      qneg_r <= 1'b0;
      rneg_r <= 1'b0;
      dz_r   <= 1'b0;
      res_r  <= 32'd0;
    end else if (start_s) begin
      cnt_r  <= {CW{1'b0}};
      rem_r  <= 32'd0;
      quo_r  <= (signed_op_s & src1_r[31]) ? -src1_r : src1_r;
      dsor_r <= (signed_op_s & src2_r[31]) ? -src2_r : src2_r;
      qneg_r <= signed_op_s & (src1_r[31] ^ src2_r[31]);
      rneg_r <= signed_op_s & src1_r[31];
      dz_r   <= (src2_r == 32'd0);
    end else if (run_s) begin
      cnt_r <= cnt_r + CW'(1);
      rem_r <= rem_nxt_s;
      quo_r <= quo_nxt_s;
      if (last_s) begin
        res_r <= (alu_op_r[16] | alu_op_r[18]) ? rem_fin_s : quo_fin_s;
      end
    end
  end

  assign out_alu_result = is_div_s ? res_r : alu_s;
`else
  assign exe_ready_go_s = 1'b1;
  assign out_alu_result = is_div_s ? 32'd0 : alu_s;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector table through a scoreboard plus handshake corner sequences.
module tb_exe_stage;

`ifdef EXE_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        id_to_exe_valid;
  logic        exe_allow_in;
  logic        exe_to_pmem_valid;
  logic        pmem_allow_in;
  logic [18:0] in_alu_op;
  logic [31:0] in_src1, in_src2;
  logic [4:0]  in_rf_w_addr;
  logic        in_rf_w_en, in_rf_w_data_sel;
  logic [5:0]  in_ram_ctrl;
  logic [31:0] in_ram_wdata, in_pc;
  logic [31:0] out_alu_result;
  logic [4:0]  out_rf_w_addr;
  logic        out_rf_w_en, out_rf_w_data_sel;
  logic [5:0]  out_ram_ctrl;
  logic [31:0] out_ram_wdata, out_pc;
  logic        by_rf_w_data_valid, by_valid;

  exe_stage dut (
    .clk(clk), .resetn(resetn),
    .id_to_exe_valid(id_to_exe_valid), .exe_allow_in(exe_allow_in),
    .exe_to_pmem_valid(exe_to_pmem_valid), .pmem_allow_in(pmem_allow_in),
    .in_alu_op(in_alu_op), .in_src1(in_src1), .in_src2(in_src2),
    .in_rf_w_addr(in_rf_w_addr), .in_rf_w_en(in_rf_w_en), .in_rf_w_data_sel(in_rf_w_data_sel),
    .in_ram_ctrl(in_ram_ctrl), .in_ram_wdata(in_ram_wdata), .in_pc(in_pc),
    .out_alu_result(out_alu_result), .out_rf_w_addr(out_rf_w_addr), .out_rf_w_en(out_rf_w_en),
    .out_rf_w_data_sel(out_rf_w_data_sel), .out_ram_ctrl(out_ram_ctrl),
    .out_ram_wdata(out_ram_wdata), .out_pc(out_pc),
    .by_rf_w_data_valid(by_rf_w_data_valid), .by_valid(by_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [5:0]  ctrl;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int seq = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every handoff toward PMEM against the oldest pending expectation.
  always @(negedge clk) begin
    if (resetn && exe_to_pmem_valid && pmem_allow_in) begin
      if (sb.size() == 0) begin
        chk("unexpected_handoff", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", out_alu_result, e.res);
        chk("pc", out_pc, e.pc);
        chk("rf_w_addr", {27'd0, out_rf_w_addr}, {27'd0, e.addr});
        chk("ram_ctrl", {26'd0, out_ram_ctrl}, {26'd0, e.ctrl});
        chk("ram_wdata", out_ram_wdata, e.wdata);
      end
    end
  end

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic wen, input logic sel);
    int n;
    exp_t e;
    @(negedge clk);
    in_alu_op        = 19'd1 << op;
    in_src1          = a;
    in_src2          = b;
    in_rf_w_addr     = seq[4:0];
    in_rf_w_en       = wen;
    in_rf_w_data_sel = sel;
    in_ram_ctrl      = seq[5:0] ^ 6'h2A;
    in_ram_wdata     = ~a;
    in_pc            = 32'h0000_1000 + (32'(seq) << 2);
    id_to_exe_valid  = 1'b1;
    n = 0;
    while (!exe_allow_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!exe_allow_in) begin
      chk("issue_timeout", 32'd1, 32'd0);
    end else begin
      e.res = exp; e.pc = in_pc; e.addr = in_rf_w_addr; e.ctrl = in_ram_ctrl; e.wdata = in_ram_wdata;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    id_to_exe_valid = 1'b0;
    seq++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [31:0] dv(input logic [31:0] v);
    return DIV_ON ? v : 32'd0;
  endfunction

  vec_t vecs[24];
  int   cnt;
  logic [31:0] pc_hold;

  initial begin
    vecs[0]  = '{0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    vecs[2]  = '{2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[3]  = '{2,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[4]  = '{3,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[5]  = '{4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[6]  = '{5,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F};
    vecs[7]  = '{6,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    vecs[8]  = '{7,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vecs[9]  = '{8,  32'h0000_0001, 32'h0000_0023, 32'h0000_0008};
    vecs[10] = '{9,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
    vecs[11] = '{10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
    vecs[12] = '{11, 32'hDEAD_BEEF, 32'h1234_0000, 32'h1234_0000};
    vecs[13] = '{12, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
    vecs[14] = '{13, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[15] = '{14, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[16] = '{15, 32'hFFFF_FFF9, 32'h0000_0002, dv(32'hFFFF_FFFD)};
    vecs[17] = '{16, 32'hFFFF_FFF9, 32'h0000_0002, dv(32'hFFFF_FFFF)};
    vecs[18] = '{17, 32'h0000_0007, 32'h0000_0002, dv(32'h0000_0003)};
    vecs[19] = '{17, 32'h0000_0005, 32'h0000_0000, dv(32'hFFFF_FFFF)};
    vecs[20] = '{18, 32'h0000_0005, 32'h0000_0000, dv(32'h0000_0005)};
    vecs[21] = '{15, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h8000_0000)};
    vecs[22] = '{16, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h0000_0000)};
    vecs[23] = '{16, 32'hFFFF_FFF9, 32'h0000_0000, dv(32'hFFFF_FFF9)};

    resetn = 1'b0; id_to_exe_valid = 1'b0; pmem_allow_in = 1'b1;
    in_alu_op = 19'd0; in_src1 = 32'd0; in_src2 = 32'd0; in_rf_w_addr = 5'd0;
    in_rf_w_en = 1'b0; in_rf_w_data_sel = 1'b0; in_ram_ctrl = 6'd0; in_ram_wdata = 32'd0; in_pc = 32'd0;
    #3;
    chk("rst_allow_in", {31'd0, exe_allow_in}, 32'd1);
    chk("rst_to_pmem_valid", {31'd0, exe_to_pmem_valid}, 32'd0);
    chk("rst_by_rf_valid", {31'd0, by_rf_w_data_valid}, 32'd0);
    chk("rst_by_valid", {31'd0, by_valid}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Table: issued back to back, so consecutive divides exercise the IDLE re-entry.
    for (int i = 0; i < 24; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1, 1'b0);
    end
    drain();

    // add: handoff and bypass in the cycle after latch.
    issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("add_to_pmem_valid", {31'd0, exe_to_pmem_valid}, 32'd1);
    chk("add_by_rf_valid", {31'd0, by_rf_w_data_valid}, 32'd1);
    drain();

    // div occupancy: allow_in held low for the entry cycle plus every RUN cycle.
    issue(15, 32'hFFFF_FFF9, 32'h0000_0002, dv(32'hFFFF_FFFD), 1'b1, 1'b0);
    @(negedge clk);
    chk("div_by_valid", {31'd0, by_valid}, 32'd1);
    chk("div_by_rf_early", {31'd0, by_rf_w_data_valid}, DIV_ON ? 32'd0 : 32'd1);
    cnt = 0;
    while (!exe_allow_in && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("div_stall_cycles", 32'(cnt), DIV_ON ? 32'd33 : 32'd0);
    chk("div_done_valid", {31'd0, exe_to_pmem_valid}, 32'd1);
    chk("div_done_by_rf", {31'd0, by_rf_w_data_valid}, 32'd1);
    drain();

    // Backpressure: outputs hold while PMEM refuses, handoff when it accepts.
    pmem_allow_in = 1'b0;
    issue(0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b1, 1'b0);
    pc_hold = 32'h0000_1000 + (32'(seq - 1) << 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_allow_in", {31'd0, exe_allow_in}, 32'd0);
      chk("bp_valid", {31'd0, exe_to_pmem_valid}, 32'd1);
      chk("bp_result", out_alu_result, 32'h0000_0003);
      chk("bp_pc", out_pc, pc_hold);
    end
    @(posedge clk);
    #1;
    pmem_allow_in = 1'b1;
    @(negedge clk);
    chk("bp_release_allow_in", {31'd0, exe_allow_in}, 32'd1);
    @(negedge clk);
    chk("bp_after_by_valid", {31'd0, by_valid}, 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Load: address is valid but the write data is not forwardable.
    issue(0, 32'h0000_0100, 32'h0000_0004, 32'h0000_0104, 1'b1, 1'b1);
    @(negedge clk);
    chk("load_by_valid", {31'd0, by_valid}, 32'd1);
    chk("load_by_rf_valid", {31'd0, by_rf_w_data_valid}, 32'd0);
    drain();

    // Asynchronous reset in the middle of a divide, then a normal divide.
    pmem_allow_in = 1'b0;
    issue(15, 32'hFFFF_FFF9, 32'h0000_0002, dv(32'hFFFF_FFFD), 1'b1, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_by_valid", {31'd0, by_valid}, 32'd0);
    chk("mid_rst_to_pmem", {31'd0, exe_to_pmem_valid}, 32'd0);
    chk("mid_rst_allow_in", {31'd0, exe_allow_in}, 32'd1);
    chk("mid_rst_pc", out_pc, 32'd0);
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    pmem_allow_in = 1'b1;
    issue(17, 32'h0000_0007, 32'h0000_0002, dv(32'h0000_0003), 1'b1, 1'b0);
    drain();
    chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
